// File: rtl/mac_accum_3c.sv
// mac_accum_3c: signed multiply-accumulate behind a LAT-deep DSP multiplier; one result per in_last group.
// Latency: a one-pair group accepted at edge E gives out_valid after edge E+LAT; one pair per clock.
// Backpressure: out_valid & ~out_ready freezes the DSP and flag pipe and drops in_ready. MAC_ACCUM_SAT_EN clamps sums.
module mac_accum_3c #(
  parameter int LAT   = 3,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [17:0]             in_a,
  input  logic [17:0]             in_b,
  input  logic                    in_last,
  output logic [17:0]             mul_a,
  output logic [17:0]             mul_b,
  output logic                    mul_en,
  output logic                    mul_rst,
  input  logic [35:0]             mul_p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_acc,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_sat
);

  logic                    stall;
  logic                    accept;
  logic [LAT-1:0]          vld;
  logic [LAT-1:0]          lst;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_inc;

  assign stall    = out_valid & ~out_ready;
  assign mul_en   = ~stall;
  assign in_ready = ~stall & rst;
  assign accept   = in_valid & in_ready;
  assign mul_rst  = ~rst;
  assign mul_a    = in_a;
  assign mul_b    = in_b;

  assign p_ext   = ACC_W'($signed(mul_p));
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

`ifdef MAC_ACCUM_SAT_EN
  logic [ACC_W:0] wide;
  logic           sat_now;
  logic           sat;

  // One guard bit: overflow shows as the guard disagreeing with the result sign.
  assign wide = {acc[ACC_W-1], acc} + {p_ext[ACC_W-1], p_ext};

  always_comb begin
    sum     = wide[ACC_W-1:0];
    sat_now = 1'b0;
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      sat_now = 1'b1;
      sum     = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sat     <= 1'b0;
      out_sat <= 1'b0;
    end else if (mul_en && vld[LAT-1]) begin
      if (lst[LAT-1]) begin
        out_sat <= sat | sat_now;
        sat     <= 1'b0;
      end else begin
        sat <= sat | sat_now;
      end
    end
  end
`else
  assign sum     = acc + p_ext;
  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld       <= '0;
      lst       <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      // Flags advance only with the DSP so vld[LAT-1] always tags the current mul_p.
      if (mul_en) begin
        vld <= LAT'({vld, accept});
        lst <= LAT'({lst, in_last & accept});
        if (vld[LAT-1]) begin
          if (lst[LAT-1]) begin
            out_acc   <= sum;
            out_count <= cnt_inc;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
          end else begin
            acc <= sum;
            cnt <= cnt_inc;
          end
        end
      end
    end
  end

endmodule
